// File: rtl/fir_channel_scheduler.sv
// ---------------------------------------------------------------------------
// fir_channel_scheduler
//   Shares one sequential FIR engine between NUM_CH sample requesters.
//   A round-robin arbiter grants one channel at a time. The granted sample is
//   forwarded to the engine over a valid/ready handshake. The filtered result
//   is captured and returned downstream, tagged with the channel index.
//   Only one sample is in flight at any time.
//
//   Optional feature: define FIR_SCHED_TIMEOUT_EN to add a watchdog. The
//   watchdog aborts a transaction that spends TIMEOUT_CYCLES in ISSUE+BUSY.
//
// Ports
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_en              grant enable (blocks new grants only)
//   iv_ch_din         packed per-channel samples, channel k at [k*DW +: DW]
//   iv_ch_valid       per-channel sample valid (level)
//   ov_ch_ready       one-hot pulse: that channel's sample was taken
//   ov_eng_din        sample to engine
//   o_eng_din_valid   sample valid to engine
//   i_eng_ready       engine consumed sample
//   iv_eng_dout       engine result
//   i_eng_dout_valid  engine result valid
//   o_eng_ready       pulse: result consumed
//   o_eng_rst         engine abort reset (watchdog only)
//   ov_dout           tagged result
//   ov_dout_ch        channel index of ov_dout
//   o_dout_valid      result valid, held until i_dout_ready
//   i_dout_ready      downstream accepts result
//   o_timeout         pulse: transaction aborted (watchdog only)
// ---------------------------------------------------------------------------
module fir_channel_scheduler #(
    parameter int DATA_WIDTH     = 24,
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   iv_ch_din,
    input  logic [NUM_CH-1:0]              iv_ch_valid,
    output logic [NUM_CH-1:0]              ov_ch_ready,
    output logic [DATA_WIDTH-1:0]          ov_eng_din,
    output logic                           o_eng_din_valid,
    input  logic                           i_eng_ready,
    input  logic [DATA_WIDTH-1:0]          iv_eng_dout,
    input  logic                           i_eng_dout_valid,
    output logic                           o_eng_ready,
    output logic                           o_eng_rst,
    output logic [DATA_WIDTH-1:0]          ov_dout,
    output logic [$clog2(NUM_CH)-1:0]      ov_dout_ch,
    output logic                           o_dout_valid,
    input  logic                           i_dout_ready,
    output logic                           o_timeout
);

    localparam int CH_WIDTH = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESULT} state_t;

    state_t                state_reg, state_next;
    logic [CH_WIDTH-1:0]   ptr_reg;
    logic [CH_WIDTH-1:0]   grant_ch_reg;
    logic [DATA_WIDTH-1:0] sample_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic [CH_WIDTH-1:0]   dout_ch_reg;
    logic                  dout_valid_reg;

    logic                  grant_valid;
    logic [CH_WIDTH-1:0]   grant_idx;
    logic                  take;
    logic                  capture;
    logic                  timeout;

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = iv_ch_din[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search. Offsets are walked from farthest to nearest, so
    // the channel closest after the pointer is the last one assigned and
    // therefore wins.
    always_comb begin
        logic [CH_WIDTH-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = CH_WIDTH'((int'(ptr_reg) + off) % NUM_CH);
            if (iv_ch_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign take    = (state_reg == IDLE) && i_en && grant_valid && !i_rst;
    // A watchdog abort takes priority over a result arriving in the same cycle.
    assign capture = (state_reg == BUSY) && i_eng_dout_valid && !timeout && !i_rst;

`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_WIDTH-1:0] timer_reg;

    // The timer is zero in the first ISSUE cycle. It therefore reads
    // TIMEOUT_CYCLES-1 on the TIMEOUT_CYCLES-th ISSUE/BUSY cycle.
    assign timeout = ((state_reg == ISSUE) || (state_reg == BUSY)) &&
                     (timer_reg == TMR_WIDTH'(TIMEOUT_CYCLES - 1)) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst || take) begin
            timer_reg <= '0;
        end else if ((state_reg == ISSUE) || (state_reg == BUSY)) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (take) state_next = ISSUE;
            ISSUE:  if (timeout) state_next = IDLE;
                    else if (i_eng_ready) state_next = BUSY;
            BUSY:   if (timeout) state_next = IDLE;
                    else if (i_eng_dout_valid) state_next = RESULT;
            RESULT: if (i_dout_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ov_ch_ready = '0;
        if (take) begin
            ov_ch_ready[grant_idx] = 1'b1;
        end
        o_eng_din_valid = (state_reg == ISSUE);
        o_eng_ready     = capture;
        o_eng_rst       = timeout;
        o_timeout       = timeout;
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_reg        <= CH_WIDTH'(NUM_CH - 1);
            grant_ch_reg   <= '0;
            sample_reg     <= '0;
            dout_reg       <= '0;
            dout_ch_reg    <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (take) begin
                sample_reg   <= ch_data[grant_idx];
                grant_ch_reg <= grant_idx;
                ptr_reg      <= grant_idx;
            end
            if (capture) begin
                dout_reg       <= iv_eng_dout;
                dout_ch_reg    <= grant_ch_reg;
                dout_valid_reg <= 1'b1;
            end else if ((state_reg == RESULT) && i_dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign ov_eng_din   = sample_reg;
    assign ov_dout      = dout_reg;
    assign ov_dout_ch   = dout_ch_reg;
    assign o_dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
module tb_fir_channel_scheduler;

    localparam int DW = 24;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_en = 1'b1;
    logic [NCH*DW-1:0] iv_ch_din = '0;
    logic [NCH-1:0]   iv_ch_valid = '0;
    logic [NCH-1:0]   ov_ch_ready;
    logic [DW-1:0]    ov_eng_din;
    logic             o_eng_din_valid;
    logic             i_eng_ready = 1'b0;
    logic [DW-1:0]    iv_eng_dout = '0;
    logic             i_eng_dout_valid = 1'b0;
    logic             o_eng_ready;
    logic             o_eng_rst;
    logic [DW-1:0]    ov_dout;
    logic [1:0]       ov_dout_ch;
    logic             o_dout_valid;
    logic             i_dout_ready = 1'b1;
    logic             o_timeout;

    fir_channel_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .TIMEOUT_CYCLES(64)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en),
        .iv_ch_din(iv_ch_din), .iv_ch_valid(iv_ch_valid), .ov_ch_ready(ov_ch_ready),
        .ov_eng_din(ov_eng_din), .o_eng_din_valid(o_eng_din_valid), .i_eng_ready(i_eng_ready),
        .iv_eng_dout(iv_eng_dout), .i_eng_dout_valid(i_eng_dout_valid), .o_eng_ready(o_eng_ready),
        .o_eng_rst(o_eng_rst), .ov_dout(ov_dout), .ov_dout_ch(ov_dout_ch),
        .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready), .o_timeout(o_timeout)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int grants_seen = 0;
    int accept_seen = 0;
    int last_grant = -1;
    int g_mark = 0;
    int a_target = 0;
    int eng_lat = 2;
    bit eng_dead = 1'b0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [DW-1:0] dout;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]    mask;
        logic [DW-1:0] base;
        int            lat;
        int            exp_ch;
    } vec_t;
    vec_t vecs[10];

    // Behavioural FIR engine: result is the sample times ten.
    function automatic logic [DW-1:0] eng_f(input logic [DW-1:0] x);
        return x * 24'd10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected event", name);
    endtask

    // Engine model, driven just after each falling edge.
    initial begin
        int ph = 0;
        int cnt = 0;
        logic [DW-1:0] smp = '0;
        forever begin
            @(negedge clk);
            #1;
            if (i_rst || o_eng_rst) begin
                ph = 0;
                i_eng_ready = 1'b0;
                i_eng_dout_valid = 1'b0;
            end else begin
                case (ph)
                    0: if (o_eng_din_valid && !eng_dead) begin
                           smp = ov_eng_din;
                           i_eng_ready = 1'b1;
                           ph = 1;
                       end
                    1: begin
                           i_eng_ready = 1'b0;
                           cnt = eng_lat;
                           ph = 2;
                       end
                    2: if (cnt <= 1) begin
                           iv_eng_dout = eng_f(smp);
                           i_eng_dout_valid = 1'b1;
                           ph = 3;
                       end else begin
                           cnt--;
                       end
                    default: begin
                           i_eng_dout_valid = 1'b0;
                           ph = 0;
                       end
                endcase
            end
        end
    end

    // Monitor: sees settled values that the next rising edge will sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!i_rst) begin
                if (ov_ch_ready != '0) begin
                    chk("ready_onehot", 32'($countones(ov_ch_ready)), 32'd1);
                    for (int k = 0; k < NCH; k++) if (ov_ch_ready[k]) last_grant = k;
                    grants_seen++;
                end
                if (i_eng_dout_valid) chk("eng_ready_pulse", {31'd0, o_eng_ready}, 32'd1);
                if (o_dout_valid && i_dout_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("sb_unexpected_result");
                    end else begin
                        e = sb.pop_front();
                        chk("dout", {8'd0, ov_dout}, {8'd0, e.dout});
                        chk("dout_ch", {30'd0, ov_dout_ch}, {30'd0, e.ch});
                        $display("txn ch=%0d dout=%06h exp_ch=%0d exp_dout=%06h",
                                 ov_dout_ch, ov_dout, e.ch, e.dout);
                    end
                    accept_seen++;
                end
            end
        end
    end

    task automatic drive_req(input logic [3:0] mask, input logic [DW-1:0] base,
                             input int lat, input int exp_ch, input bit push);
        exp_t e;
        eng_lat = lat;
        for (int k = 0; k < NCH; k++) iv_ch_din[k*DW +: DW] = base + DW'(k);
        iv_ch_valid = mask;
        g_mark = grants_seen;
        a_target = accept_seen + 1;
        if (push) begin
            e.ch = 2'(exp_ch);
            e.dout = eng_f(base + DW'(exp_ch));
            sb.push_back(e);
        end
    endtask

    task automatic wait_grant(input int exp_ch);
        #3;
        for (int c = 0; c < 60 && grants_seen == g_mark; c++) begin
            @(negedge clk);
            #3;
        end
        if (grants_seen == g_mark) fail_now("grant_timeout");
        else chk("grant_ch", 32'(last_grant), 32'(exp_ch));
    endtask

    task automatic wait_accept();
        for (int c = 0; c < 400 && accept_seen < a_target; c++) begin
            @(negedge clk);
            #3;
        end
        if (accept_seen < a_target) fail_now("accept_timeout");
    endtask

    task automatic run_row(input logic [3:0] mask, input logic [DW-1:0] base,
                           input int lat, input int exp_ch);
        @(negedge clk);
        drive_req(mask, base, lat, exp_ch, 1'b1);
        wait_grant(exp_ch);
        @(negedge clk);
        iv_ch_valid = '0;
        wait_accept();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {24'd0, ov_ch_ready, o_eng_din_valid, o_eng_ready, o_eng_rst, o_timeout},
            32'd0);
        chk({name, "_dv"}, {31'd0, o_dout_valid}, 32'd0);
        chk({name, "_dout"}, {6'd0, ov_dout_ch, ov_dout}, 32'd0);
        chk({name, "_engdin"}, {8'd0, ov_eng_din}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 24'h000010, 2,  0};
        vecs[1] = '{4'b1111, 24'h000020, 3,  1};
        vecs[2] = '{4'b1111, 24'h000030, 1,  2};
        vecs[3] = '{4'b1111, 24'h000040, 0,  3};
        vecs[4] = '{4'b1111, 24'h000050, 4,  0};
        vecs[5] = '{4'b0100, 24'h0000FE, 20, 2};   // ch2 sample 0x100 -> 0xA00
        vecs[6] = '{4'b0100, 24'h000060, 2,  2};   // single requester back-to-back
        vecs[7] = '{4'b1001, 24'h000070, 2,  3};
        vecs[8] = '{4'b1001, 24'h000080, 1,  0};   // wrap-around
        vecs[9] = '{4'b0011, 24'hFFFFF0, 2,  1};   // result truncation

        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        #3;
        chk_all_zero("reset");

        for (int i = 0; i < 10; i++) run_row(vecs[i].mask, vecs[i].base, vecs[i].lat, vecs[i].exp_ch);

        // Enable low blocks the grant; it resumes in the cycle enable returns.
        @(negedge clk);
        i_en = 1'b0;
        drive_req(4'b0010, 24'h000500, 2, 1, 1'b1);
        repeat (8) @(negedge clk);
        #3;
        chk("en_low_no_grant", 32'(grants_seen), 32'(g_mark));
        @(negedge clk);
        i_en = 1'b1;
        #3;
        chk("en_high_grant", 32'(grants_seen), 32'(g_mark + 1));
        chk("en_high_grant_ch", 32'(last_grant), 32'd1);
        @(negedge clk);
        iv_ch_valid = '0;
        wait_accept();

        // Downstream stall: result held steady and no new grant.
        @(negedge clk);
        i_dout_ready = 1'b0;
        drive_req(4'b1000, 24'h000123, 3, 3, 1'b1);
        wait_grant(3);
        @(negedge clk);
        iv_ch_valid = '0;
        for (int c = 0; c < 60 && !o_dout_valid; c++) begin
            @(negedge clk);
            #3;
        end
        if (!o_dout_valid) fail_now("stall_result_timeout");
        @(negedge clk);
        drive_req(4'b0001, 24'h000700, 2, 0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            chk("stall_valid", {31'd0, o_dout_valid}, 32'd1);
            chk("stall_dout", {8'd0, ov_dout}, {8'd0, eng_f(24'h000126)});
        end
        chk("stall_no_grant", 32'(grants_seen), 32'(g_mark));
        @(negedge clk);
        i_dout_ready = 1'b1;
        a_target = accept_seen + 2;
        wait_grant(0);
        @(negedge clk);
        iv_ch_valid = '0;
        wait_accept();

        // Reset while the engine is busy.
        @(negedge clk);
        drive_req(4'b0001, 24'h000200, 30, 0, 1'b1);
        wait_grant(0);
        @(negedge clk);
        iv_ch_valid = '0;
        repeat (4) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        #3;
        chk_all_zero("midrst");
        void'(sb.pop_back());
        run_row(4'b0011, 24'h000300, 2, 0);        // pointer back at NUM_CH-1
        run_row(4'b0010, 24'h000310, 2, 1);

`ifdef FIR_SCHED_TIMEOUT_EN
        begin
            int cyc = 0;
            bit seen = 1'b0;
            eng_dead = 1'b1;
            @(negedge clk);
            drive_req(4'b0100, 24'h000400, 2, 2, 1'b0);
            wait_grant(2);
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                iv_ch_valid = '0;
                #3;
                cyc++;
                if (o_timeout) begin
                    seen = 1'b1;
                    chk("timeout_eng_rst", {31'd0, o_eng_rst}, 32'd1);
                end
            end
            if (!seen) fail_now("timeout_missing");
            chk("timeout_cycle", 32'(cyc), 32'd64);
            @(negedge clk);
            #3;
            chk("timeout_idle", {30'd0, o_eng_din_valid, o_timeout}, 32'd0);
            eng_dead = 1'b0;
            run_row(4'b0100, 24'h000410, 2, 2);
        end
`endif

        repeat (3) @(negedge clk);
        if (sb.size() != 0) fail_now("sb_leftover");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
